// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: external multiplexed bus cycle sequencer (ADDR -> LATCH -> DATA -> RECOVER).
// Optional macro EXT_BUS_RDY_EN adds a bus_rdy input that stretches the data phase.
module ext_bus_ctrl #(
    parameter int ADDR_SETUP  = 1,
    parameter int WAIT_STATES = 1,
    parameter int RECOVERY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [19:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic [19:0] io_out,
    output logic [19:0] io_oe,
    input  logic [15:0] io_in,
`ifdef EXT_BUS_RDY_EN
    input  logic        bus_rdy,
`endif
    output logic        ale,
    output logic        oe_n,
    output logic        we_n,
    output logic        pio
);
    typedef enum logic [2:0] {IDLE, ADDR, LATCH, DATA, RECOVER} state_t;

    localparam logic [3:0] SETUP_LD = 4'(ADDR_SETUP - 1);
    localparam logic [3:0] WAIT_LD  = 4'(WAIT_STATES);
    localparam logic [3:0] REC_LD   = 4'(RECOVERY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [3:0]  addr_hi;
    logic [15:0] wdata_q;
    logic        data_done;

    if (ADDR_SETUP < 1 || ADDR_SETUP > 7) begin : g_bad_setup
        $error("ext_bus_ctrl: ADDR_SETUP must be 1..7");
    end

`ifdef EXT_BUS_RDY_EN
    assign data_done = (cnt == 4'd0) && bus_rdy;
`else
    assign data_done = cnt == 4'd0;
`endif

    // Bus cycle FSM; every bus strobe is set on the edge entering its state so all outputs are glitch-free flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            we_q       <= 1'b0;
            addr_hi    <= 4'd0;
            wdata_q    <= 16'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 16'd0;
            io_out     <= 20'd0;
            io_oe      <= 20'd0;
            ale        <= 1'b0;
            oe_n       <= 1'b1;
            we_n       <= 1'b1;
            pio        <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    state     <= ADDR;
                    cnt       <= SETUP_LD;
                    we_q      <= req_we;
                    addr_hi   <= req_addr[19:16];
                    wdata_q   <= req_wdata;
                    io_out    <= req_addr;
                    io_oe     <= 20'hFFFFF;
                    ale       <= 1'b1;
                    req_ready <= 1'b0;
                end
                ADDR: if (cnt == 4'd0) begin
                    state <= LATCH;
                    ale   <= 1'b0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                LATCH: begin
                    state  <= DATA;
                    cnt    <= WAIT_LD;
                    pio    <= 1'b1;
                    oe_n   <= 1'b0;
                    we_n   <= ~we_q;
                    io_out <= {addr_hi, wdata_q};
                    io_oe  <= {4'hF, {16{we_q}}};
                end
                DATA: if (data_done) begin
                    if (!we_q) resp_rdata <= io_in;
                    resp_valid <= 1'b1;
                    pio        <= 1'b0;
                    oe_n       <= 1'b1;
                    we_n       <= 1'b1;
                    io_oe      <= 20'd0;
                    if (RECOVERY == 0) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        state <= RECOVER;
                        cnt   <= REC_LD;
                    end
                end else if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end
                RECOVER: if (cnt == 4'd0) begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
